gate_sweep_checker: RTL

- Sequential stimulus/check controller wrapped around the 7-output two-input gate bank.
- Drives the gate bank's a/b inputs through all four {a,b} vectors (00, 01, 10, 11) and samples the 7-bit result after a settle window.
- Compares each sample against a golden table and reports a per-gate fail mask, a mismatch count and a pass flag.
- Serves as the built-in self-test stage for the gate bank.

---
 rtl/gate_check_pkg.sv | 29 ++
 rtl/gate_golden.sv | 11 +
 rtl/gate_sweep_checker.sv | 113 +++++++++++
 3 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate-bank self-test controller.
// GOLDEN rows are indexed by {a,b}; bit 0 of each row is the NOT-a output.
package gate_check_pkg;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    localparam int G_NOT  = 0;
    localparam int G_AND  = 1;
    localparam int G_OR   = 2;
    localparam int G_NAND = 3;
    localparam int G_NOR  = 4;
    localparam int G_XOR  = 5;
    localparam int G_XNOR = 6;

    localparam logic [0:3][0:6] GOLDEN = {
        7'b1001101,
        7'b1011010,
        7'b0011010,
        7'b0110001
    };

    function automatic logic [2:0] popcount7(input logic [0:6] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 7; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/gate_golden.sv
// Expected gate-bank response for one {a,b} input vector.
module gate_golden
    import gate_check_pkg::*;
(
    input  logic [1:0] idx,
    output logic [0:6] expected
);

    assign expected = GOLDEN[idx];

endmodule

// File: rtl/gate_sweep_checker.sv
// Built-in self-test sequencer: sweeps the gate bank through all four input
// vectors N_PASSES times and accumulates a per-gate fail mask and bit-error count.
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int N_PASSES      = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:6]       y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [0:6]       fail_mask,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_PASS   = 4'(N_PASSES - 1);
    localparam int         SW          = CNT_W + 4;

    state_t     state;
    logic [1:0] idx;
    logic [3:0] pass_cnt;
    logic [3:0] settle_cnt;

    logic [0:6]       expected;
    logic [0:6]       diff;
    logic [0:6]       mask_next;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] count_next;

    gate_golden u_golden (
        .idx      (idx),
        .expected (expected)
    );

    always_comb begin
        diff       = y_in ^ expected;
        mask_next  = fail_mask | diff;
        sum        = SW'(err_count) + SW'(popcount7(diff));
        count_next = (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
    end

    // The gate inputs are updated on the edge that enters DRIVE, so the bank
    // sees a stable vector for DRIVE + SETTLE_CYCLES + 1 edges before SAMPLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            err_count  <= '0;
            idx        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        fail_mask      <= '0;
                        err_count      <= '0;
                        pass           <= 1'b0;
                        idx            <= '0;
                        pass_cnt       <= '0;
                        {a_out, b_out} <= 2'b00;
                        busy           <= 1'b1;
                        state          <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    fail_mask <= mask_next;
                    err_count <= count_next;
                    if (idx != 2'd3) begin
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                        state          <= S_DRIVE;
                    end else if (pass_cnt != LAST_PASS) begin
                        idx            <= '0;
                        pass_cnt       <= pass_cnt + 4'd1;
                        {a_out, b_out} <= 2'b00;
                        state          <= S_DRIVE;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (mask_next == '0);
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
